// File: rtl/spi_flash_line_buffer.sv
// Single-line instruction prefetch buffer in front of the SPI flash controller.
// A miss fetches a whole aligned line byte by byte. In-line hits are then served in one cycle.
module spi_flash_line_buffer #(
    parameter int LINE_BYTES = 16,
    parameter int ADDR_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  chipSel,
    input  logic                  readMem,
    input  logic [ADDR_WIDTH-1:0] addressBus,
    output logic [7:0]            dataOut,
    output logic                  ready,
    input  logic                  invalidate,
    output logic                  flashCS,
    output logic                  flashRead,
    output logic [ADDR_WIDTH-1:0] flashAddr,
    input  logic [7:0]            flashData,
    input  logic                  flashReady,
    output logic [15:0]           missCount
);
    localparam int OFS = $clog2(LINE_BYTES);
    localparam int TAG_W = ADDR_WIDTH - OFS;
    localparam logic [OFS-1:0] LAST_IDX = '1;

    typedef enum logic [2:0] {IDLE, RESP, FILL_REQ, FILL_GAP, FILL_DONE} stateT;

    stateT state, stateNext;

    logic [7:0]            lineMem [LINE_BYTES];
    logic [TAG_W-1:0]      tagReg;
    logic                  valid;
    logic                  invPend;
    logic [ADDR_WIDTH-1:0] reqAddr;
    logic [OFS-1:0]        fillIdx;

    logic request;
    logic hit;

    assign request = chipSel & readMem;
    // A concurrent invalidate forces the request down the miss path.
    assign hit = valid & (addressBus[ADDR_WIDTH-1:OFS] == tagReg) & ~invalidate;

    assign ready     = (state == RESP);
    assign flashCS   = (state == FILL_REQ);
    assign flashRead = (state == FILL_REQ);
    assign flashAddr = (state == FILL_REQ) ? {reqAddr[ADDR_WIDTH-1:OFS], fillIdx} : '0;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:      if (request) stateNext = hit ? RESP : FILL_REQ;
            RESP:      stateNext = IDLE;
            FILL_REQ:  if (flashReady) stateNext = FILL_GAP;
            FILL_GAP:  stateNext = (fillIdx == LAST_IDX) ? FILL_DONE : FILL_REQ;
            FILL_DONE: stateNext = RESP;
            default:   stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            valid     <= 1'b0;
            invPend   <= 1'b0;
            fillIdx   <= '0;
            dataOut   <= 8'h00;
            missCount <= 16'h0000;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: begin
                    if (invalidate) valid <= 1'b0;
                    if (request) begin
                        if (hit) begin
                            dataOut <= lineMem[addressBus[OFS-1:0]];
                        end else begin
                            fillIdx <= '0;
                            invPend <= 1'b0;
                            valid   <= 1'b0;
                            if (missCount != 16'hFFFF) missCount <= missCount + 16'd1;
                        end
                    end
                end
                RESP: begin
                    if (invalidate) valid <= 1'b0;
                end
                FILL_REQ: begin
                    if (invalidate) invPend <= 1'b1;
                end
                FILL_GAP: begin
                    if (invalidate) invPend <= 1'b1;
                    if (fillIdx != LAST_IDX) fillIdx <= fillIdx + OFS'(1);
                end
                FILL_DONE: begin
                    // An invalidate anywhere in the fill leaves the line unusable for later hits.
                    valid   <= ~(invPend | invalidate);
                    dataOut <= lineMem[reqAddr[OFS-1:0]];
                end
                default: ;
            endcase
        end
    end

    // Line storage, tag and captured address carry no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && request && !hit) reqAddr <= addressBus;
        if (state == FILL_REQ && flashReady) lineMem[fillIdx] <= flashData;
        if (state == FILL_DONE) tagReg <= reqAddr[ADDR_WIDTH-1:OFS];
    end

endmodule

// File: tb/tb_spi_flash_line_buffer.sv
// Bench for spi_flash_line_buffer: directed scenarios plus random reads, checked against
// a line-level cache model and a flash responder that records every fetched address.
module tb_spi_flash_line_buffer;
    localparam int LB  = 16;
    localparam int AW  = 24;
    localparam int OFS = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          chipSel;
    logic          readMem;
    logic [AW-1:0] addressBus;
    logic [7:0]    dataOut;
    logic          ready;
    logic          invalidate;
    logic          flashCS;
    logic          flashRead;
    logic [AW-1:0] flashAddr;
    logic [7:0]    flashData;
    logic          flashReady;
    logic [15:0]   missCount;

    int nAsrt = 0;
    int nFail = 0;
    int flashLat = 3;
    int gapViol = 0;
    int stabViol = 0;
    logic [AW-1:0] fetchQ[$];

    bit              mValid = 1'b0;
    logic [AW-OFS-1:0] mTag = '0;
    int              mMiss = 0;

    spi_flash_line_buffer #(.LINE_BYTES(LB), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .chipSel(chipSel), .readMem(readMem),
        .addressBus(addressBus), .dataOut(dataOut), .ready(ready),
        .invalidate(invalidate), .flashCS(flashCS), .flashRead(flashRead),
        .flashAddr(flashAddr), .flashData(flashData), .flashReady(flashReady),
        .missCount(missCount)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] flashByte(input logic [AW-1:0] a);
        return a[7:0] ^ a[23:16];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsrt++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Flash responder: answers after flashLat cycles of held request, logs addresses.
    initial begin : flashModel
        int cnt;
        logic prevReady;
        logic [AW-1:0] holdAddr;
        cnt = 0;
        prevReady = 1'b0;
        holdAddr = '0;
        flashReady = 1'b0;
        flashData = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            prevReady = flashReady;
            flashReady = 1'b0;
            if (flashCS === 1'b1 && flashRead === 1'b1) begin
                if (prevReady) gapViol++;
                if (cnt == 0) holdAddr = flashAddr;
                else if (flashAddr !== holdAddr) stabViol++;
                cnt++;
                if (cnt >= flashLat) begin
                    flashReady = 1'b1;
                    flashData = flashByte(flashAddr);
                    fetchQ.push_back(flashAddr);
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic doRead(input logic [AW-1:0] a, input bit invWithReq, input int invAt, input int rstAt);
        bit expHit;
        bit got;
        bit invDone;
        bit orderOk;
        bit anyReady;
        int lat;
        logic [7:0] gotData;
        logic [AW-1:0] base;
        expHit = mValid && (mTag == a[AW-1:OFS]) && !invWithReq;
        base = {a[AW-1:OFS], {OFS{1'b0}}};
        fetchQ.delete();
        gapViol = 0;
        stabViol = 0;
        got = 1'b0;
        invDone = 1'b0;
        lat = 0;
        gotData = 8'h00;
        chipSel = 1'b1;
        readMem = 1'b1;
        addressBus = a;
        invalidate = invWithReq;
        for (int k = 1; k <= 4000 && !got; k++) begin
            @(posedge clk);
            #2;
            invalidate = 1'b0;
            if (ready === 1'b1) begin
                got = 1'b1;
                lat = k;
                gotData = dataOut;
                chipSel = 1'b0;
                readMem = 1'b0;
            end else if (rstAt >= 0 && fetchQ.size() == rstAt && flashCS === 1'b1) begin
                rst = 1'b1;
                @(posedge clk);
                #2;
                rst = 1'b0;
                chipSel = 1'b0;
                readMem = 1'b0;
                chk("rstFlashCS", flashCS, 0);
                chk("rstFlashRead", flashRead, 0);
                chk("rstFlashAddr", flashAddr, 0);
                chk("rstReady", ready, 0);
                chk("rstMissCount", missCount, 0);
                mValid = 1'b0;
                mMiss = 0;
                anyReady = 1'b0;
                repeat (20) begin
                    @(posedge clk);
                    #2;
                    if (ready !== 1'b0 || flashCS !== 1'b0) anyReady = 1'b1;
                end
                chk("rstNoReadyAfter", anyReady, 0);
                return;
            end else if (invAt >= 0 && !invDone && fetchQ.size() == invAt && flashCS === 1'b1) begin
                invalidate = 1'b1;
                invDone = 1'b1;
            end
        end
        chk("gotReady", got, 1);
        if (got) begin
            chk("data", gotData, flashByte(a));
            if (expHit) begin
                chk("hitLatency", lat, 1);
                chk("hitNoFlash", fetchQ.size(), 0);
            end else begin
                chk("fillCount", fetchQ.size(), LB);
                orderOk = 1'b1;
                for (int i = 0; i < LB && i < fetchQ.size(); i++)
                    if (fetchQ[i] !== base + AW'(i)) orderOk = 1'b0;
                chk("fillOrder", orderOk, 1);
                chk("fillGap", gapViol, 0);
                chk("fillStable", stabViol, 0);
                if (mMiss < 65535) mMiss++;
                mValid = !invDone;
                mTag = a[AW-1:OFS];
            end
            chk("missCount", missCount, mMiss);
            @(posedge clk);
            #2;
            chk("singlePulse", ready, 0);
        end
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [AW-OFS-1:0] pool [3];
        bit anyAct;
        logic [AW-1:0] ra;
        int ia;
        rst = 1'b1;
        chipSel = 1'($urandom);
        readMem = 1'($urandom);
        addressBus = AW'($urandom);
        invalidate = 1'($urandom);
        repeat (2) begin
            @(posedge clk);
            #2;
            chipSel = 1'($urandom);
            readMem = 1'($urandom);
            addressBus = AW'($urandom);
            invalidate = 1'($urandom);
        end
        rst = 1'b0;
        chipSel = 1'b0;
        readMem = 1'b0;
        invalidate = 1'b0;
        addressBus = '0;
        chk("resetReady", ready, 0);
        chk("resetFlashCS", flashCS, 0);
        chk("resetFlashRead", flashRead, 0);
        chk("resetFlashAddr", flashAddr, 0);
        chk("resetMissCount", missCount, 0);
        chk("resetDataOut", dataOut, 0);

        flashLat = 3;
        doRead(24'h000104, 1'b0, -1, -1);
        doRead(24'h00010F, 1'b0, -1, -1);
        doRead(24'h000110, 1'b0, -1, -1);
        doRead(24'h000104, 1'b0, -1, -1);

        doRead(24'h000200, 1'b0, 4, -1);
        doRead(24'h000201, 1'b0, -1, -1);
        doRead(24'h000205, 1'b0, -1, -1);

        // Select without read: nothing must happen.
        chipSel = 1'b1;
        readMem = 1'b0;
        addressBus = 24'h000203;
        anyAct = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #2;
            if (ready !== 1'b0 || flashCS !== 1'b0) anyAct = 1'b1;
        end
        chipSel = 1'b0;
        chk("selNoRead", anyAct, 0);

        invalidate = 1'b1;
        @(posedge clk);
        #2;
        invalidate = 1'b0;
        mValid = 1'b0;
        doRead(24'h000203, 1'b0, -1, -1);
        doRead(24'h000207, 1'b1, -1, -1);
        doRead(24'h000208, 1'b0, -1, -1);

        doRead(24'h000345, 1'b0, -1, 7);
        doRead(24'h000345, 1'b0, -1, -1);

        flashLat = 1;
        doRead(24'hFFFFF7, 1'b0, -1, -1);
        doRead(24'hFFFFF0, 1'b0, -1, -1);
        doRead(24'hFFFFFF, 1'b0, -1, -1);

        pool[0] = 20'h00010;
        pool[1] = 20'($urandom);
        pool[2] = 20'hFFFFF;
        for (int n = 0; n < 40; n++) begin
            flashLat = $urandom_range(1, 4);
            ra = {pool[$urandom_range(0, 2)], 4'($urandom)};
            ia = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, LB - 1)) : -1;
            doRead(ra, ($urandom_range(0, 7) == 0), ia, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsrt, nFail);
        $finish;
    end
endmodule
